spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI slave receiver: the far end of the board's 8-bit SPI master link (CS, SCLK, MOSI). It oversamples the three SPI pins in the MAX10_CLK1_50 domain, assembles MSB-first bytes in SPI mode 0, and buffers them in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake. It serves as the on-board loopback/capture endpoint for the SPI transmit path and as the receive side for host-to-FPGA command bytes.

## Interface
- DATA_W, 8, bits per SPI word
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, ≥2)
- SYNC_STAGES, 2, synchronizer flops per SPI input (≥2)
- MAX10_CLK1_50  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-low
- spi_cs_n  in  1  chip select, active-low, asynchronous to clock
- spi_sclk  in  1  SPI clock, idle low, asynchronous
- spi_mosi  in  1  serial data, asynchronous
- rx_data  out  DATA_W  FIFO head byte, valid when rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head this cycle when rx_valid=1
- frame_active  out  1  synchronized CS asserted and receiver armed
- frame_bytes  out  8  full bytes received in current/last frame, saturates at 255
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full
- frame_err  out  1  sticky: CS deasserted with a partial byte (1..DATA_W-1 bits)
- err_clr  in  1  single-cycle clear of overflow and frame_err

## Operation
- Each SPI input passes through SYNC_STAGES flops, then one extra flop for edge detection. sclk_rise = sync high and prev low. cs_fall / cs_rise are derived the same way.
- States: WAIT_IDLE, IDLE, SHIFT.
- Reset enters WAIT_IDLE. Synchronizer flops reset to cs_n=1, sclk=0, mosi=0.
- WAIT_IDLE → IDLE when synchronized cs_n=1. Deassertion of reset while CS is already low never starts a frame mid-stream.
- IDLE → SHIFT on cs_fall. In the same cycle: bit_cnt←0, shift reg←0, frame_bytes←0.
- SHIFT: on sclk_rise, shift_reg←{shift_reg[DATA_W-2:0], mosi_sync} and bit_cnt+1.
  - When bit_cnt reaches DATA_W on that edge, the completed byte is pushed and bit_cnt←0.
  - frame_bytes increments, saturating at 255.
- SHIFT → IDLE on cs_rise. The partial byte is discarded. If bit_cnt≠0, frame_err←1.
- SCLK edges while not in SHIFT are ignored.
- frame_active = (state==SHIFT).
- FIFO push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the byte is dropped, overflow←1, and FIFO contents are unchanged.
- Pop when rx_valid & rx_ready. rx_data is the registered head, read first-word-fall-through.
- err_clr clears both sticky flags. If an error sets in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, frame_active=0, frame_bytes=0, overflow=0, frame_err=0.
  - FIFO empty, bit_cnt=0.
- Pin-to-detect latency: SYNC_STAGES+1 cycles (3 at default) from an input transition to its edge strobe.
- Push-to-rx_valid: rx_valid and rx_data are updated on the clock edge after the push cycle. The FIFO has 1 cycle of latency.
- A pop-and-push on an empty FIFO cannot occur, since rx_valid=0 means no pop.
- Pop only: rx_valid deasserts on the next edge when the last entry is popped.
- Max SCLK = clk/8 (6.25 MHz); SCLK high and low must each be ≥4 clk cycles.
- CS setup to first SCLK rise and CS hold after last SCLK rise: ≥4 clk cycles each.
- Back-to-back bytes within one CS frame are supported with no gap.
- Asynchronous reset mid-frame clears everything immediately. Reception resumes only after CS is observed high.

## Test plan
- Reset, then one frame of 0xA5 at SCLK=clk/26, rx_ready=1 → exactly one rx_valid pulse with rx_data=0xA5; frame_bytes=1; no flags set.
- One CS frame of 0x0F,0x3C,0xFF,0x00,0x81, rx_ready=0 during the frame, then drained → first 4 bytes read in order (0x0F,0x3C,0xFF,0x00); 0x81 dropped; overflow=1; frame_bytes=5.
- CS rises after 5 bits, then a full frame with 0x5A → frame_err=1; only 0x5A reaches the FIFO. err_clr then drops frame_err to 0 on the next cycle.
- Assert rst while CS is low mid-byte, release while CS is still low, clock 8 more SCLK edges, then CS high, then a frame of 0xC3 → the bytes before CS high are ignored; only 0xC3 is received; no flags set.
- FIFO full with rx_ready=1 exactly in the cycle a 5th byte (0x77) completes → no overflow; 0x77 is read last.
- SCLK toggled 16 times with CS high → rx_valid stays 0; frame_active stays 0; frame_bytes unchanged.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronizes CS/SCLK/MOSI into the system clock,
// assembles MSB-first words and queues them in a small first-word-fall-through
// FIFO that downstream logic drains with a valid/ready handshake.
module spi_slave_rx #(
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              MAX10_CLK1_50,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_active,
   output logic [7:0]        frame_bytes,
   output logic              overflow,
   output logic              frame_err,
   input  logic              err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_W);
   localparam int SW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] cs_sync_reg, sclk_sync_reg, mosi_sync_reg;
   logic                   cs_prev_reg, sclk_prev_reg;
   logic                   cs_s, sclk_s, mosi_s;
   logic                   cs_fall, cs_rise, sclk_rise;
   logic [SW-1:0]          settle_reg;
   logic                   settle_done;

   state_t                 state_reg, state_next;
   logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
   logic [DATA_W-1:0]      shift_reg, shift_next;
   logic [7:0]             frame_bytes_reg, frame_bytes_next;
   logic [DATA_W-1:0]      push_data;
   logic                   push, frame_err_set;

   logic [DATA_W-1:0]      mem [FIFO_DEPTH];
   logic [AW:0]            wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
   logic                   full, pop, push_ok, ovf_set;
   logic [DATA_W-1:0]      rx_data_reg;
   logic                   rx_valid_reg, overflow_reg, frame_err_reg;

   // Synchronizer chains plus one history flop for edge detection on CS and SCLK.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         cs_sync_reg   <= '1;
         sclk_sync_reg <= '0;
         mosi_sync_reg <= '0;
         cs_prev_reg   <= 1'b1;
         sclk_prev_reg <= 1'b0;
      end else begin
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
         cs_prev_reg   <= cs_s;
         sclk_prev_reg <= sclk_s;
      end
   end

   assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
   assign cs_fall   = ~cs_s & cs_prev_reg;
   assign cs_rise   = cs_s & ~cs_prev_reg;
   assign sclk_rise = sclk_s & ~sclk_prev_reg;

   // The synchronizer's reset value of CS=1 is not a real observation of the pin;
   // count SYNC_STAGES cycles after reset before trusting a "CS high" reading.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst)
         settle_reg <= '0;
      else if (!settle_done)
         settle_reg <= settle_reg + SW'(1);
   end

   assign settle_done = (settle_reg == SW'(SYNC_STAGES));

   // Receiver state, bit counter, shift register and per-frame byte count.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         state_reg       <= WAIT_IDLE;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         frame_bytes_reg <= '0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         frame_bytes_reg <= frame_bytes_next;
      end
   end

   // Next-state logic: frame start/end on CS edges, bit capture on SCLK rises.
   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      frame_bytes_next = frame_bytes_reg;
      push             = 1'b0;
      frame_err_set    = 1'b0;
      push_data        = {shift_reg[DATA_W-2:0], mosi_s};
      case (state_reg)
         WAIT_IDLE: begin
            if (settle_done && cs_s)
               state_next = IDLE;
         end
         IDLE: begin
            if (cs_fall) begin
               state_next       = SHIFT;
               bit_cnt_next     = '0;
               shift_next       = '0;
               frame_bytes_next = '0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_next = IDLE;
               if (bit_cnt_reg != '0)
                  frame_err_set = 1'b1;
            end else if (sclk_rise) begin
               shift_next = push_data;
               if (bit_cnt_reg == BW'(DATA_W - 1)) begin
                  push         = 1'b1;
                  bit_cnt_next = '0;
                  if (frame_bytes_reg != 8'hFF)
                     frame_bytes_next = frame_bytes_reg + 8'd1;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BW'(1);
               end
            end
         end
         default: state_next = WAIT_IDLE;
      endcase
   end

   // A full FIFO still accepts a word when the head is popped in the same cycle.
   assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop         = rx_valid_reg & rx_ready;
   assign push_ok     = push & (~full | pop);
   assign ovf_set     = push & full & ~pop;
   assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
   assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};

   // FIFO storage; no reset so it maps onto block RAM.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   // Pointers, registered head word (bypassing a write into an empty FIFO) and sticky flags.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         rx_valid_reg <= (wr_ptr_next != rd_ptr_next);
         if (push_ok || pop) begin
            if (push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
               rx_data_reg <= push_data;
            else
               rx_data_reg <= mem[rd_ptr_next[AW-1:0]];
         end
         overflow_reg  <= ovf_set | (overflow_reg & ~err_clr);
         frame_err_reg <= frame_err_set | (frame_err_reg & ~err_clr);
      end
   end

   assign rx_data      = rx_data_reg;
   assign rx_valid     = rx_valid_reg;
   assign frame_active = (state_reg == SHIFT);
   assign frame_bytes  = frame_bytes_reg;
   assign overflow     = overflow_reg;
   assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives SPI frames bit by bit and checks received
// bytes and status outputs against a queue-based reference of the receiver.
module tb_spi_slave_rx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready = 1'b0;
   logic       frame_active, overflow, frame_err, err_clr = 1'b0;
   logic [7:0] frame_bytes;

   int errors = 0;
   int checks = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rcv_q[$];
   logic [7:0] exp_q[$];

   spi_slave_rx #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .MAX10_CLK1_50(clk), .rst(rst),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_active(frame_active), .frame_bytes(frame_bytes),
      .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #10 clk = ~clk;

   // Every accepted handshake (valid & ready before the rising edge) is one received byte.
   always @(negedge clk) begin
      if (rx_valid === 1'b1 && rx_ready === 1'b1)
         rcv_q.push_back(rx_data);
   end

   // Inputs change 2 ns after the rising edge; outputs are read at the falling edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic apply_reset();
      spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
      rx_ready = 1'b0; err_clr = 1'b0;
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(6);
      rcv_q.delete();
   endtask

   // Mode 0: MOSI set during SCLK low, sampled on the rise. Optionally pulse
   // rx_ready for exactly the cycle in which the last bit's rise is detected.
   task automatic send_bits(input logic [7:0] b, input int nbits, input int half, input bit pulse_last);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = b[7-i];
         tick(half);
         spi_sclk = 1'b1;
         if (pulse_last && i == nbits - 1) begin
            tick(2);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            tick(half - 3);
         end else begin
            tick(half);
         end
         spi_sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input int half, input bit pulse_last);
      spi_cs_n = 1'b0;
      tick(half);
      for (int i = 0; i < tx_q.size(); i++)
         send_bits(tx_q[i], 8, half, pulse_last && (i == tx_q.size() - 1));
      tick(half);
      spi_cs_n = 1'b1;
      tick(half + 2);
      $display("frame: %0d bytes, half period %0d clk", tx_q.size(), half);
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
      checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active: got %0b expected 0", frame_active); end
      checks++; if (frame_bytes !== 8'd0) begin errors++; $display("FAIL reset_frame_bytes: got %0d expected 0", frame_bytes); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
      $display("reset: outputs inspected");
   endtask

   task automatic test_single_byte();
      apply_reset();
      rx_ready = 1'b1;
      spi_cs_n = 1'b0;
      tick(13);
      @(negedge clk);
      checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL single_frame_active: got %0b expected 1", frame_active); end
      send_bits(8'hA5, 8, 13, 1'b0);
      tick(13);
      spi_cs_n = 1'b1;
      tick(15);
      rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         checks++; if (rcv_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", rcv_q[0]); end
      end
      checks++; if (frame_bytes !== 8'd1) begin errors++; $display("FAIL single_frame_bytes: got %0d expected 1", frame_bytes); end
      checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL single_flags: got ovf=%0b ferr=%0b expected 0/0", overflow, frame_err); end
      checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL single_frame_end: got %0b expected 0", frame_active); end
      $display("single byte: received %0d byte(s)", rcv_q.size());
   endtask

   task automatic test_overflow();
      logic exp_ovf;
      apply_reset();
      tx_q = '{8'h0F, 8'h3C, 8'hFF, 8'h00, 8'h81};
      exp_q.delete(); exp_ovf = 1'b0;
      foreach (tx_q[i]) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(tx_q[i]);
         else exp_ovf = 1'b1;
      end
      send_frame($urandom_range(4, 8), 1'b0);
      @(negedge clk);
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %0b expected %0b", overflow, exp_ovf); end
      checks++; if (frame_bytes !== 8'd5) begin errors++; $display("FAIL ovf_frame_bytes: got %0d expected 5", frame_bytes); end
      rx_ready = 1'b1; tick(3 * DEPTH); rx_ready = 1'b0; tick(1);
      checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
         checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", i, rcv_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_frame_err();
      apply_reset();
      spi_cs_n = 1'b0;
      tick(5);
      send_bits(8'($urandom), 5, 5, 1'b0);
      tick(5);
      spi_cs_n = 1'b1;
      tick(8);
      $display("partial frame: 5 bits");
      @(negedge clk);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %0b expected 1", frame_err); end
      tx_q = '{8'h5A};
      send_frame(5, 1'b0);
      rx_ready = 1'b1; tick(3 * DEPTH); rx_ready = 1'b0; tick(1);
      checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         checks++; if (rcv_q[0] !== 8'h5A) begin errors++; $display("FAIL ferr_data: got %0h expected 5a", rcv_q[0]); end
      end
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %0b expected 1", frame_err); end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      @(negedge clk);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %0b expected 0", frame_err); end
      $display("err_clr: pulsed");
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      spi_cs_n = 1'b0;
      tick(6);
      send_bits(8'hFF, 3, 6, 1'b0);
      #5 rst = 1'b0;
      #1;
      checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL midrst_async: got %0b expected 0", frame_active); end
      tick(2);
      rst = 1'b1;
      send_bits(8'($urandom), 8, 6, 1'b0);
      tick(6);
      spi_cs_n = 1'b1;
      tick(10);
      @(negedge clk);
      checks++; if (rx_valid !== 1'b0 || frame_bytes !== 8'd0) begin errors++; $display("FAIL midrst_ignored: got valid=%0b bytes=%0d expected 0/0", rx_valid, frame_bytes); end
      rx_ready = 1'b1;
      tx_q = '{8'hC3};
      send_frame(6, 1'b0);
      rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", rcv_q.size()); end
      if (rcv_q.size() > 0) begin
         checks++; if (rcv_q[0] !== 8'hC3) begin errors++; $display("FAIL midrst_data: got %0h expected c3", rcv_q[0]); end
      end
      checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ovf=%0b ferr=%0b expected 0/0", overflow, frame_err); end
      checks++; if (frame_bytes !== 8'd1) begin errors++; $display("FAIL midrst_frame_bytes: got %0d expected 1", frame_bytes); end
   endtask

   task automatic test_full_pop_push();
      apply_reset();
      tx_q.delete();
      for (int i = 0; i < DEPTH; i++) tx_q.push_back(8'($urandom));
      tx_q.push_back(8'h77);
      // Head is consumed exactly as the last byte lands, so nothing is lost.
      exp_q = tx_q;
      send_frame(6, 1'b1);
      @(negedge clk);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL popfull_ovf: got %0b expected 0", overflow); end
      rx_ready = 1'b1; tick(3 * DEPTH); rx_ready = 1'b0; tick(1);
      checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL popfull_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
         checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL popfull_data[%0d]: got %0h expected %0h", i, rcv_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_sclk_without_cs();
      int bad;
      apply_reset();
      rx_ready = 1'b1;
      tx_q = '{8'($urandom), 8'($urandom)};
      send_frame(5, 1'b0);
      bad = 0;
      for (int t = 0; t < 16; t++) begin
         spi_mosi = 1'($urandom);
         spi_sclk = ~spi_sclk;
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (frame_active !== 1'b0 || (rx_valid !== 1'b0 && rcv_q.size() >= 2)) bad++;
            @(posedge clk);
            #2;
         end
      end
      tick(4);
      rx_ready = 1'b0;
      $display("idle sclk: 16 toggles with CS high");
      @(negedge clk);
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_activity: got %0d busy cycles expected 0", bad); end
      checks++; if (frame_bytes !== 8'd2) begin errors++; $display("FAIL idle_frame_bytes: got %0d expected 2", frame_bytes); end
      checks++; if (rcv_q.size() !== 2) begin errors++; $display("FAIL idle_count: got %0d expected 2", rcv_q.size()); end
      for (int i = 0; i < 2 && i < rcv_q.size(); i++) begin
         checks++; if (rcv_q[i] !== tx_q[i]) begin errors++; $display("FAIL idle_data[%0d]: got %0h expected %0h", i, rcv_q[i], tx_q[i]); end
      end
   endtask

   task automatic test_random_frames();
      for (int it = 0; it < 6; it++) begin
         int  n;
         int  half;
         logic rdy, exp_ovf;
         apply_reset();
         n    = $urandom_range(1, 6);
         half = $urandom_range(4, 10);
         rdy  = 1'($urandom);
         tx_q.delete(); exp_q.delete(); exp_ovf = 1'b0;
         for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
         foreach (tx_q[i]) begin
            if (rdy || exp_q.size() < DEPTH) exp_q.push_back(tx_q[i]);
            else exp_ovf = 1'b1;
         end
         rx_ready = rdy;
         send_frame(half, 1'b0);
         rx_ready = 1'b0;
         @(negedge clk);
         checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand%0d_ovf: got %0b expected %0b", it, overflow, exp_ovf); end
         checks++; if (frame_bytes !== 8'(n)) begin errors++; $display("FAIL rand%0d_frame_bytes: got %0d expected %0d", it, frame_bytes, n); end
         rx_ready = 1'b1; tick(3 * DEPTH); rx_ready = 1'b0; tick(1);
         checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, rcv_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d]: got %0h expected %0h", it, i, rcv_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_overflow();
      test_frame_err();
      test_reset_mid_frame();
      test_full_pop_push();
      test_sclk_without_cs();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
